// File: rtl/regfile_param.sv
// regfile_param: parametrised register file for the decode stage.
// It has NUM_REGS registers of DATA_W bits each.
// It has one synchronous write port with a per-byte write mask.
// It has two combinational read ports.
// It has an optional hardwired-zero register at index ZERO_REG.
//
// Reset ('reset') is asynchronous and active-low. It clears every register.
//
// Build option: define REGFILE_BYPASS_EN to turn on write-to-read forwarding.
// A read of the register being written then returns the merged value in the same cycle.
module regfile_param #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = NUM_REGS - 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [$clog2(NUM_REGS)-1:0] write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [DATA_W/8-1:0]      byte_en,
  input  logic [$clog2(NUM_REGS)-1:0] read_reg1,
  input  logic [$clog2(NUM_REGS)-1:0] read_reg2,
  output logic [DATA_W-1:0]        read_data1,
  output logic [DATA_W-1:0]        read_data2
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int NBYTES = DATA_W / 8;

  // An index outside the array disables the zero register.
  localparam bit HAS_ZERO = (ZERO_REG < NUM_REGS);

  // byte_en expanded to one mask bit per data bit.
  logic [DATA_W-1:0] wmask;

  // Current contents of every register, as seen by the read muxes.
  logic [DATA_W-1:0] reg_val [NUM_REGS];

  genvar gi;

  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_mask
      assign wmask[8*gi +: 8] = {8{byte_en[gi]}};
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (HAS_ZERO && (gi == ZERO_REG)) begin : g_zero
        // The hardwired-zero slot has no storage. Writes to it simply have no target.
        assign reg_val[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] val_q;
        logic [DATA_W-1:0] val_d;

        // Next value: merge the masked write bytes when this register is addressed.
        always_comb begin
          val_d = val_q;
          if (write_enable && (write_reg == ADDR_W'(gi))) begin
            val_d = (val_q & ~wmask) | (write_data & wmask);
          end
        end

        // Storage flop. The async clear also blocks any write while reset is low.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            val_q <= '0;
          end else begin
            val_q <= val_d;
          end
        end

        assign reg_val[gi] = val_q;
      end
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  logic              wr_zero;
  logic              fwd_ok;
  logic [DATA_W-1:0] fwd_val;

  assign wr_zero = HAS_ZERO && (write_reg == ADDR_W'(ZERO_REG));
  assign fwd_ok  = reset && write_enable && !wr_zero;
  assign fwd_val = (reg_val[write_reg] & ~wmask) | (write_data & wmask);

  // Read muxes with forwarding of the in-flight write (writeback -> decode).
  always_comb begin
    read_data1 = reg_val[read_reg1];
    read_data2 = reg_val[read_reg2];
    if (fwd_ok && (write_reg == read_reg1)) begin
      read_data1 = fwd_val;
    end
    if (fwd_ok && (write_reg == read_reg2)) begin
      read_data2 = fwd_val;
    end
  end
`else
  // Plain read muxes: stored contents only. A write shows up after its commit edge.
  always_comb begin
    read_data1 = reg_val[read_reg1];
    read_data2 = reg_val[read_reg2];
  end
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param with its default parameters.
// These are 64-bit data, 32 registers, and the zero register at index 31.
module tb_regfile_param;

  logic        clk;
  logic        reset;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [63:0] write_data;
  logic [7:0]  byte_en;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [63:0] read_data1;
  logic [63:0] read_data2;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_param dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .byte_en      (byte_en),
    .read_reg1    (read_reg1),
    .read_reg2    (read_reg2),
    .read_data1   (read_data1),
    .read_data2   (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helper: one committed write, with inputs set up at the falling edge.
  task automatic do_write(input logic [4:0] a, input logic [63:0] d, input logic [7:0] be);
    @(negedge clk);
    write_enable = 1'b1;
    write_reg    = a;
    write_data   = d;
    byte_en      = be;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    byte_en      = 8'h00;
  endtask

  task automatic test_reset;
    read_reg1 = 5'd0;
    read_reg2 = 5'd17;
    #2;
    n_checks++;
    if (read_data1 !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_r0: got %h expected %h", read_data1, 64'h0);
    end
    n_checks++;
    if (read_data2 !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_r17: got %h expected %h", read_data2, 64'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    do_write(5'd5, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    read_reg1 = 5'd5;
    #1;
    n_checks++;
    if (read_data1 !== 64'hDEAD_BEEF_0123_4567) begin
      n_fail++;
      $display("FAIL preload_r5: got %h expected %h", read_data1, 64'hDEAD_BEEF_0123_4567);
    end
    // Assert reset between edges. The clear must be visible before the next rising edge.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (read_data1 !== 64'h0) begin
      n_fail++;
      $display("FAIL async_clear_r5: got %h expected %h", read_data1, 64'h0);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (read_data1 !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_hold_r5: got %h expected %h", read_data1, 64'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (read_data1 !== 64'h0) begin
      n_fail++;
      $display("FAIL post_reset_r5: got %h expected %h", read_data1, 64'h0);
    end
  endtask

  task automatic test_enable;
    @(negedge clk);
    write_enable = 1'b0;
    write_reg    = 5'd3;
    write_data   = 64'h1;
    byte_en      = 8'hFF;
    read_reg1    = 5'd3;
    @(posedge clk);
    #1;
    n_checks++;
    if (read_data1 !== 64'h0) begin
      n_fail++;
      $display("FAIL we0_r3: got %h expected %h", read_data1, 64'h0);
    end
    do_write(5'd3, 64'h1, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (read_data1 !== 64'h1) begin
        n_fail++;
        $display("FAIL we1_hold_r3 cycle %0d: got %h expected %h", i, read_data1, 64'h1);
      end
      @(posedge clk);
      #1;
    end
    read_reg2 = 5'd4;
    #1;
    n_checks++;
    if (read_data2 !== 64'h0) begin
      n_fail++;
      $display("FAIL neighbour_r4: got %h expected %h", read_data2, 64'h0);
    end
  endtask

  task automatic test_byte_mask;
    read_reg1 = 5'd7;
    do_write(5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    n_checks++;
    if (read_data1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL mask_ff_r7: got %h expected %h", read_data1, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    do_write(5'd7, 64'h0, 8'h0F);
    n_checks++;
    if (read_data1 !== 64'hFFFF_FFFF_0000_0000) begin
      n_fail++;
      $display("FAIL mask_0f_r7: got %h expected %h", read_data1, 64'hFFFF_FFFF_0000_0000);
    end
    do_write(5'd7, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00);
    n_checks++;
    if (read_data1 !== 64'hFFFF_FFFF_0000_0000) begin
      n_fail++;
      $display("FAIL mask_00_r7: got %h expected %h", read_data1, 64'hFFFF_FFFF_0000_0000);
    end
    do_write(5'd7, 64'h1122_3344_5566_7788, 8'h81);
    n_checks++;
    if (read_data1 !== 64'h11FF_FFFF_0000_0088) begin
      n_fail++;
      $display("FAIL mask_81_r7: got %h expected %h", read_data1, 64'h11FF_FFFF_0000_0088);
    end
  endtask

  task automatic test_zero_reg;
    do_write(5'd30, 64'h3030_3030_3030_3030, 8'hFF);
    read_reg1 = 5'd31;
    read_reg2 = 5'd30;
    @(negedge clk);
    write_enable = 1'b1;
    write_reg    = 5'd31;
    write_data   = 64'hAAAA_AAAA_AAAA_AAAA;
    byte_en      = 8'hFF;
    #1;
    n_checks++;
    if (read_data1 !== 64'h0) begin
      n_fail++;
      $display("FAIL zero_during_write: got %h expected %h", read_data1, 64'h0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (read_data1 !== 64'h0) begin
        n_fail++;
        $display("FAIL zero_r31 cycle %0d: got %h expected %h", i, read_data1, 64'h0);
      end
    end
    write_enable = 1'b0;
    byte_en      = 8'h00;
    n_checks++;
    if (read_data2 !== 64'h3030_3030_3030_3030) begin
      n_fail++;
      $display("FAIL zero_neighbour_r30: got %h expected %h", read_data2, 64'h3030_3030_3030_3030);
    end
  endtask

  task automatic test_dual_read;
    do_write(5'd2, 64'h22, 8'hFF);
    do_write(5'd9, 64'h99, 8'hFF);
    read_reg1 = 5'd2;
    read_reg2 = 5'd9;
    #1;
    n_checks++;
    if (read_data1 !== 64'h22) begin
      n_fail++;
      $display("FAIL dual_rd1: got %h expected %h", read_data1, 64'h22);
    end
    n_checks++;
    if (read_data2 !== 64'h99) begin
      n_fail++;
      $display("FAIL dual_rd2: got %h expected %h", read_data2, 64'h99);
    end
    read_reg2 = 5'd2;
    #1;
    n_checks++;
    if (read_data2 !== 64'h22) begin
      n_fail++;
      $display("FAIL same_idx_rd2: got %h expected %h", read_data2, 64'h22);
    end
  endtask

  task automatic test_collision;
    logic [63:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 64'h55;
`else
    exp_pre = 64'h22;
`endif
    read_reg1 = 5'd2;
    read_reg2 = 5'd9;
    @(negedge clk);
    write_enable = 1'b1;
    write_reg    = 5'd2;
    write_data   = 64'h55;
    byte_en      = 8'hFF;
    #1;
    n_checks++;
    if (read_data1 !== exp_pre) begin
      n_fail++;
      $display("FAIL collision_pre: got %h expected %h", read_data1, exp_pre);
    end
    n_checks++;
    if (read_data2 !== 64'h99) begin
      n_fail++;
      $display("FAIL collision_other_port: got %h expected %h", read_data2, 64'h99);
    end
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    byte_en      = 8'h00;
    n_checks++;
    if (read_data1 !== 64'h55) begin
      n_fail++;
      $display("FAIL collision_post: got %h expected %h", read_data1, 64'h55);
    end
  endtask

  task automatic test_reset_during_write;
    read_reg1 = 5'd4;
    read_reg2 = 5'd2;
    @(negedge clk);
    write_enable = 1'b1;
    write_reg    = 5'd4;
    write_data   = 64'h44;
    byte_en      = 8'hFF;
    reset        = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (read_data1 !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_write_r4_in_reset: got %h expected %h", read_data1, 64'h0);
    end
    @(negedge clk);
    write_enable = 1'b0;
    byte_en      = 8'h00;
    reset        = 1'b1;
    #1;
    n_checks++;
    if (read_data1 !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_write_r4_after: got %h expected %h", read_data1, 64'h0);
    end
    n_checks++;
    if (read_data2 !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_cleared_r2: got %h expected %h", read_data2, 64'h0);
    end
    // The first edge after release must accept a write.
    do_write(5'd4, 64'h44, 8'hFF);
    n_checks++;
    if (read_data1 !== 64'h44) begin
      n_fail++;
      $display("FAIL first_write_after_rst: got %h expected %h", read_data1, 64'h44);
    end
  endtask

  initial begin
    reset        = 1'b0;
    write_enable = 1'b0;
    write_reg    = 5'd0;
    write_data   = 64'h0;
    byte_en      = 8'h00;
    read_reg1    = 5'd0;
    read_reg2    = 5'd0;
    test_reset();
    test_enable();
    test_byte_mask();
    test_zero_reg();
    test_dual_read();
    test_collision();
    test_reset_during_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised register file that generalises the single 64-bit enabled register into an array of NUM_REGS registers of DATA_W bits.
- Provides one synchronous write port with per-byte write enables and two asynchronous read ports.
- Includes an optional hardwired-zero register.
- Sits in the decode stage of the pipelined CPU: read ports feed the ID/EX operands, and the write port is driven from writeback.

Parameters:
- DATA_W, 64, register width in bits; must be a multiple of 8.
- NUM_REGS, 32, number of registers; power of two, minimum 2.
- ADDR_W, $clog2(NUM_REGS), register-index width; derived, not overridden.
- ZERO_REG, NUM_REGS-1, index of the hardwired-zero register; a value of NUM_REGS or greater disables the zero register.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0); clears all registers.
- write_enable  input  1  commits write_data to write_reg at the rising edge.
- write_reg  input  ADDR_W  destination register index.
- write_data  input  DATA_W  data to write.
- byte_en  input  DATA_W/8  per-byte write mask; bit k gates write_data[8k+7:8k].
- read_reg1  input  ADDR_W  index for read port 1.
- read_reg2  input  ADDR_W  index for read port 2.
- read_data1  output  DATA_W  contents of read_reg1.
- read_data2  output  DATA_W  contents of read_reg2.

Behaviour:
- Reset:
  - When reset=0, all NUM_REGS registers clear to 0 immediately, without waiting for a clock edge.
  - read_data1 and read_data2 therefore read 0 for every index while reset is asserted.
  - Writes are blocked while reset=0.
  - Reset deasserts synchronously to clk; the first write is accepted on the first rising edge with reset=1.
- Write (committed at the rising edge):
  - Condition: reset=1, write_enable=1 and write_reg != ZERO_REG.
  - For each byte k with byte_en[k]=1, reg[write_reg] byte k takes write_data byte k.
  - Bytes with byte_en[k]=0 keep their value.
  - byte_en all zero: no change, same as write_enable=0.
- Hold: registers not addressed, or with write_enable=0, hold their value indefinitely.
- Read:
  - Combinational. read_dataN = reg[read_regN] with zero clock latency after an index change.
  - A write becomes visible on the read ports in the cycle after its commit edge (no bypass unless the optional feature is built in).
- Zero register:
  - If ZERO_REG < NUM_REGS, that index always reads 0.
  - Writes to it are discarded; no storage is required for it.
- Simultaneous events:
  - Both read ports may address the same register and both return the same value.
  - A read of write_reg during its write cycle returns the old value (no bypass).
- Reset mid-operation: asserting reset in the same cycle as a write discards the write; the register ends at 0.
- Out-of-range indices: cannot occur, since NUM_REGS is a power of two.
- Gate-level delay annotations are permitted but are not functional requirements.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: if write_enable=1, reset=1, write_reg == read_regN and write_reg != ZERO_REG, then read_dataN shows the merged value in the same cycle, before the edge.
  - The merged value takes write_data bytes where byte_en=1 and the stored bytes elsewhere.
  - This removes the writeback→decode hazard.
- Undefined: no forwarding; read_dataN shows stored contents only, as specified in Behaviour.

Test Plan:
- Reset clear:
  - Preload reg5=64'hDEAD_BEEF_0123_4567.
  - Drive reset=0 between clock edges → read_data1 (read_reg1=5) goes to 0 before the next rising edge.
  - Hold reset=0 → reg5 stays 0.
- Enabled vs disabled write:
  - write_enable=0, write_reg=3, write_data=64'h1, byte_en=8'hFF, one edge → read_data1 (reg3)=0.
  - Then write_enable=1, one edge → read_data1=64'h1, holding 0x1 for 5 idle cycles.
- Byte mask:
  - Set reg7=64'hFFFF_FFFF_FFFF_FFFF.
  - Write write_data=64'h0, byte_en=8'h0F → reg7=64'hFFFF_FFFF_0000_0000.
  - byte_en=8'h00 → reg7 unchanged.
- Zero register (defaults):
  - Write 64'hAAAA_AAAA_AAAA_AAAA to index 31, byte_en=8'hFF → read_data1 (reg31)=0 on every cycle.
  - Adjacent reg30 is unaffected.
- Dual read and write/read collision:
  - reg2=64'h22, reg9=64'h99; read_reg1=2, read_reg2=9 → outputs 0x22 and 0x99.
  - Write 64'h55 to reg2 with read_reg1=2:
    - Without REGFILE_BYPASS_EN: read_data1=0x22 before the edge and 0x55 after it.
    - With REGFILE_BYPASS_EN: 0x55 before the edge.
- Reset during write: write_enable=1, write_reg=4, write_data=64'h44, with reset=0 across the edge → reg4=0 after reset releases.
